// File: rtl/e_fwd_unit_if.sv
// ----------------------------------------------------------------------------
// e_fwd_unit_if
// Bundle between the E stage and the operand-forwarding unit.
//   master : pipeline side; drives E-stage producer info and source reads,
//            receives forwarded operands and the stall request.
//   slave  : the forwarding unit itself.
// Signals:
//   i_adv, i_flush          pipeline advance / kill the E instruction
//   i_e_we, i_e_rd,         E producer: write enable, destination,
//   i_e_isload, i_e_result  load flag, ALU result (address for loads)
//   i_m_loaddata            load data returned for entry 0
//   i_src_reg, i_src_data   packed source indices and register-file values
//   o_src_data, o_fwd_sel   packed forwarded operands and select codes
//   o_stall, o_stall_cnt    load-use hazard and saturating stall-cycle count
// ----------------------------------------------------------------------------
interface e_fwd_unit_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3,
    parameter int NSRC   = 2,
    parameter int SEL_W  = $clog2(DEPTH + 1)
);
    logic                     i_adv;
    logic                     i_flush;
    logic                     i_e_we;
    logic [REG_AW-1:0]        i_e_rd;
    logic                     i_e_isload;
    logic [DATA_W-1:0]        i_e_result;
    logic [DATA_W-1:0]        i_m_loaddata;
    logic [NSRC*REG_AW-1:0]   i_src_reg;
    logic [NSRC*DATA_W-1:0]   i_src_data;
    logic [NSRC*DATA_W-1:0]   o_src_data;
    logic [NSRC*SEL_W-1:0]    o_fwd_sel;
    logic                     o_stall;
    logic [15:0]              o_stall_cnt;

    modport master (
        output i_adv, i_flush, i_e_we, i_e_rd, i_e_isload, i_e_result,
               i_m_loaddata, i_src_reg, i_src_data,
        input  o_src_data, o_fwd_sel, o_stall, o_stall_cnt
    );

    modport slave (
        input  i_adv, i_flush, i_e_we, i_e_rd, i_e_isload, i_e_result,
               i_m_loaddata, i_src_reg, i_src_data,
        output o_src_data, o_fwd_sel, o_stall, o_stall_cnt
    );
endinterface

// File: rtl/e_fwd_unit.sv
// ----------------------------------------------------------------------------
// e_fwd_unit
// Operand forwarding and load-use hazard detection for the E stage.
// Keeps a DEPTH-entry shift pipeline of producers that have left E
// (entry 0 = M, entry 1 = W, ...). Each source operand takes the youngest
// matching producer; if that producer is a load still waiting for data the
// unit requests a stall instead of forwarding anything older.
// Ports:
//   i_clk   clock
//   i_rst   synchronous active-high reset
//   io_fwd  e_fwd_unit_if slave modport (see interface for signal list)
// ----------------------------------------------------------------------------
module e_fwd_unit #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3,
    parameter int NSRC   = 2,
    parameter int SEL_W  = $clog2(DEPTH + 1)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    e_fwd_unit_if.slave  io_fwd
);
    // Producer entries.
    logic [DEPTH-1:0]   r_valid;
    logic [DEPTH-1:0]   r_we;
    logic [DEPTH-1:0]   r_isload;
    logic [DEPTH-1:0]   r_ready;
    logic [REG_AW-1:0]  r_rd   [DEPTH];
    logic [DATA_W-1:0]  r_data [DEPTH];
    logic [15:0]        r_stall_cnt;

    // Values each entry takes when the pipeline advances.
    logic [DEPTH-1:0]   w_valid_next;
    logic [DEPTH-1:0]   w_we_next;
    logic [DEPTH-1:0]   w_isload_next;
    logic [DEPTH-1:0]   w_ready_next;
    logic [REG_AW-1:0]  w_rd_next   [DEPTH];
    logic [DATA_W-1:0]  w_data_next [DEPTH];

    logic               w_stall;
    logic               w_ld_done;
    logic [NSRC-1:0]    w_pend;
    logic [DEPTH-1:0]   w_match [NSRC];
    logic [NSRC*DATA_W-1:0] w_src_data;
    logic [NSRC*SEL_W-1:0]  w_fwd_sel;

    // A load sitting in entry 0 receives its data as it moves to entry 1.
    assign w_ld_done = r_valid[0] & r_isload[0];

    genvar gi;
    genvar gk;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            if (gi == 0) begin : g_head
                // A stalled or flushed E instruction enters as a bubble.
                assign w_valid_next[gi]  = ~(io_fwd.i_flush | w_stall);
                assign w_we_next[gi]     = io_fwd.i_e_we;
                assign w_rd_next[gi]     = io_fwd.i_e_rd;
                assign w_isload_next[gi] = io_fwd.i_e_isload;
                assign w_ready_next[gi]  = ~io_fwd.i_e_isload;
                assign w_data_next[gi]   = io_fwd.i_e_result;
            end else if (gi == 1) begin : g_ldret
                assign w_valid_next[gi]  = r_valid[0];
                assign w_we_next[gi]     = r_we[0];
                assign w_rd_next[gi]     = r_rd[0];
                assign w_isload_next[gi] = r_isload[0];
                assign w_ready_next[gi]  = r_ready[0] | w_ld_done;
                assign w_data_next[gi]   = w_ld_done ? io_fwd.i_m_loaddata : r_data[0];
            end else begin : g_shift
                assign w_valid_next[gi]  = r_valid[gi-1];
                assign w_we_next[gi]     = r_we[gi-1];
                assign w_rd_next[gi]     = r_rd[gi-1];
                assign w_isload_next[gi] = r_isload[gi-1];
                assign w_ready_next[gi]  = r_ready[gi-1];
                assign w_data_next[gi]   = r_data[gi-1];
            end
        end

        // r0 is never a forwarding target, so an entry writing r0 never matches.
        for (gi = 0; gi < NSRC; gi++) begin : g_src
            for (gk = 0; gk < DEPTH; gk++) begin : g_cmp
                assign w_match[gi][gk] = r_valid[gk] & r_we[gk] &
                    (r_rd[gk] == io_fwd.i_src_reg[gi*REG_AW +: REG_AW]) &
                    (r_rd[gk] != '0);
            end
        end
    endgenerate

    // Walk from oldest to youngest so the youngest match is the last writer.
    // A younger not-ready match therefore cancels any older ready one.
    always_comb begin
        w_src_data = io_fwd.i_src_data;
        w_fwd_sel  = '0;
        w_pend     = '0;
        for (int s = 0; s < NSRC; s++) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (w_match[s][k]) begin
                    if (r_ready[k]) begin
                        w_src_data[s*DATA_W +: DATA_W] = r_data[k];
                        w_fwd_sel[s*SEL_W +: SEL_W]    = SEL_W'(k + 1);
                        w_pend[s]                      = 1'b0;
                    end else begin
                        w_src_data[s*DATA_W +: DATA_W] = io_fwd.i_src_data[s*DATA_W +: DATA_W];
                        w_fwd_sel[s*SEL_W +: SEL_W]    = '0;
                        w_pend[s]                      = 1'b1;
                    end
                end
            end
        end
        w_stall = |w_pend;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid     <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (io_fwd.i_adv) begin
                r_valid  <= w_valid_next;
                r_we     <= w_we_next;
                r_isload <= w_isload_next;
                r_ready  <= w_ready_next;
                for (int k = 0; k < DEPTH; k++) begin
                    r_rd[k]   <= w_rd_next[k];
                    r_data[k] <= w_data_next[k];
                end
            end
        end
    end

    assign io_fwd.o_src_data  = w_src_data;
    assign io_fwd.o_fwd_sel   = w_fwd_sel;
    assign io_fwd.o_stall     = w_stall;
    assign io_fwd.o_stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_e_fwd_unit.sv
// ----------------------------------------------------------------------------
// tb_e_fwd_unit
// Directed bench for e_fwd_unit (DATA_W=32, REG_AW=5, DEPTH=3, NSRC=2).
// Stimulus drives inputs just after each rising edge and queues the
// hand-computed expected outputs; a monitor on the falling edge pops each
// expectation and compares it with what the unit presents.
// ----------------------------------------------------------------------------
module tb_e_fwd_unit;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int DEPTH  = 3;
    localparam int NSRC   = 2;
    localparam int SEL_W  = 2;

    typedef struct {
        int          id;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  s0;
        logic [1:0]  s1;
        logic        st;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   next_id = 1;
    exp_t q[$];

    always #5 clk = ~clk;

    e_fwd_unit_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH),
                    .NSRC(NSRC), .SEL_W(SEL_W)) u_if ();

    e_fwd_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH),
                 .NSRC(NSRC), .SEL_W(SEL_W)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_fwd (u_if)
    );

    // Monitor: one comparison per queued transaction.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [31:0] a0, a1;
            logic [1:0]  t0, t1;
            e  = q.pop_front();
            a0 = u_if.o_src_data[31:0];
            a1 = u_if.o_src_data[63:32];
            t0 = u_if.o_fwd_sel[1:0];
            t1 = u_if.o_fwd_sel[3:2];
            tests++;
            if (a0 !== e.d0 || a1 !== e.d1 || t0 !== e.s0 || t1 !== e.s1 ||
                u_if.o_stall !== e.st || u_if.o_stall_cnt !== e.cnt) begin
                fails++;
                $display("[TB] FAIL chk%0d got d0=%h d1=%h sel=%0d/%0d stall=%b cnt=%h want d0=%h d1=%h sel=%0d/%0d stall=%b cnt=%h",
                         e.id, a0, a1, t0, t1, u_if.o_stall, u_if.o_stall_cnt,
                         e.d0, e.d1, e.s0, e.s1, e.st, e.cnt);
            end else begin
                $display("[TB] chk%0d ok d0=%h d1=%h sel=%0d/%0d stall=%b cnt=%h",
                         e.id, a0, a1, t0, t1, u_if.o_stall, u_if.o_stall_cnt);
            end
        end
    end

    task automatic drive(input logic adv, input logic flush, input logic we,
                         input logic [4:0] rd, input logic ld,
                         input logic [31:0] res, input logic [31:0] lddata,
                         input logic [4:0] r0, input logic [4:0] r1,
                         input logic [31:0] d0, input logic [31:0] d1);
        u_if.i_adv        = adv;
        u_if.i_flush      = flush;
        u_if.i_e_we       = we;
        u_if.i_e_rd       = rd;
        u_if.i_e_isload   = ld;
        u_if.i_e_result   = res;
        u_if.i_m_loaddata = lddata;
        u_if.i_src_reg    = {r1, r0};
        u_if.i_src_data   = {d1, d0};
    endtask

    task automatic expect_out(input logic [31:0] d0, input logic [31:0] d1,
                              input logic [1:0] s0, input logic [1:0] s1,
                              input logic st, input logic [15:0] cnt);
        exp_t e;
        e.id = next_id; e.d0 = d0; e.d1 = d1; e.s0 = s0; e.s1 = s1;
        e.st = st; e.cnt = cnt;
        next_id++;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) tick();
        rst = 1'b0;
        // After reset: pure register-file path.
        drive(0, 0, 0, 0, 0, 0, 0, 3, 4, 32'h11, 32'h22);
        expect_out(32'h11, 32'h22, 0, 0, 0, 16'd0); tick();
        // Issue r3 <= AAAA.
        drive(1, 0, 1, 3, 0, 32'hAAAA, 0, 1, 2, 32'h1, 32'h2);
        expect_out(32'h1, 32'h2, 0, 0, 0, 16'd0); tick();
        // Unrelated r10 <= 1234; r3 from entry 0.
        drive(1, 0, 1, 10, 0, 32'h1234, 0, 3, 4, 32'h11, 32'h22);
        expect_out(32'hAAAA, 32'h22, 1, 0, 0, 16'd0); tick();
        // Non-writing op; r3 in entry 1, r10 in entry 0.
        drive(1, 0, 0, 0, 0, 0, 0, 3, 10, 32'h11, 32'h22);
        expect_out(32'hAAAA, 32'h1234, 2, 1, 0, 16'd0); tick();
        // Both sources read r3 from entry 2.
        drive(1, 0, 0, 0, 0, 0, 0, 3, 3, 32'h11, 32'h22);
        expect_out(32'hAAAA, 32'hAAAA, 3, 3, 0, 16'd0); tick();
        // r3 aged out; r10 now in entry 2.
        drive(0, 0, 0, 0, 0, 0, 0, 3, 10, 32'h33, 32'h44);
        expect_out(32'h33, 32'h1234, 0, 3, 0, 16'd0); tick();
        // Back-to-back r5 writes.
        drive(1, 0, 1, 5, 0, 32'h1, 0, 5, 0, 32'h55, 32'h66);
        expect_out(32'h55, 32'h66, 0, 0, 0, 16'd0); tick();
        drive(1, 0, 1, 5, 0, 32'h2, 0, 5, 5, 32'h0, 32'h0);
        expect_out(32'h1, 32'h1, 1, 1, 0, 16'd0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 5, 6, 32'h77, 32'h88);
        expect_out(32'h2, 32'h88, 1, 0, 0, 16'd0); tick();
        // Load r7.
        drive(1, 0, 1, 7, 1, 32'h100, 0, 1, 2, 32'h1, 32'h2);
        expect_out(32'h1, 32'h2, 0, 0, 0, 16'd0); tick();
        // Load-use: r7 stalls, r5 still forwards from entry 2.
        drive(0, 0, 0, 0, 0, 0, 0, 7, 5, 32'h70, 32'h50);
        expect_out(32'h70, 32'h2, 0, 2, 1, 16'd0); tick();
        // Advance under stall: E op bubbled, load data returns.
        drive(1, 0, 1, 8, 0, 32'h999, 32'hBEEF, 7, 5, 32'h70, 32'h50);
        expect_out(32'h70, 32'h2, 0, 2, 1, 16'd1); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 7, 8, 32'h70, 32'h80);
        expect_out(32'hBEEF, 32'h80, 2, 0, 0, 16'd2); tick();
        // Write to r0.
        drive(1, 0, 1, 0, 0, 32'h55, 0, 7, 5, 32'h0, 32'h0);
        expect_out(32'hBEEF, 32'h2, 2, 3, 0, 16'd2); tick();
        // Flushed write to r9; r0 never forwarded.
        drive(1, 1, 1, 9, 0, 32'h99, 0, 0, 7, 32'h5, 32'h6);
        expect_out(32'h5, 32'hBEEF, 0, 3, 0, 16'd2); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 9, 0, 32'h90, 32'h0A);
        expect_out(32'h90, 32'h0A, 0, 0, 0, 16'd2); tick();
        // Load r11, then hold the load-use stall until the counter saturates.
        drive(1, 0, 1, 11, 1, 32'h200, 0, 1, 2, 32'h1, 32'h2);
        expect_out(32'h1, 32'h2, 0, 0, 0, 16'd2); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 12, 11, 32'hC, 32'hB);
        expect_out(32'hC, 32'hB, 0, 0, 1, 16'd2); tick();
        repeat (69999) @(posedge clk);
        #1;
        expect_out(32'hC, 32'hB, 0, 0, 1, 16'hFFFF); tick();
        // Reset mid-stall.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_out(32'hC, 32'hB, 0, 0, 0, 16'd0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 5, 7, 32'h1, 32'h2);
        expect_out(32'h1, 32'h2, 0, 0, 0, 16'd0); tick();
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            fails++;
            $display("[TB] FAIL drain got %0d pending want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/e_fwd_unit.md
Name: e_fwd_unit

Overview:
- Parametrised operand-forwarding and load-use hazard unit for the E stage.
- Tracks the last DEPTH in-flight producers after E in an internal shift pipeline: destination register, write enable, result data and readiness.
- Forwards the youngest matching ready result to every source operand, and raises a stall when the youngest match is a load whose data has not yet returned.
- Sits between the register-file read outputs and the ALU operand inputs. Supersedes the fixed 3:1 ALU-operand feedback mux.

Parameters:
DATA_W, 32, operand/result width
REG_AW, 5, register index width; register 0 is hard-wired zero and never forwarded
DEPTH, 3, tracked producer stages after E (entry 0 = M, entry 1 = W, ...); minimum 2
NSRC, 2, number of source operands forwarded in parallel
SEL_W, $clog2(DEPTH+1), width of each forward-select code

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_adv  in  1  pipeline advances this cycle
i_flush  in  1  kill the instruction currently in E
i_e_we  in  1  E instruction writes a register
i_e_rd  in  REG_AW  E destination register
i_e_isload  in  1  E instruction is a load
i_e_result  in  DATA_W  E ALU result, or address for loads
i_m_loaddata  in  DATA_W  load data returned for entry 0
i_src_reg  in  NSRC*REG_AW  source register indices, operand s at [s*REG_AW +: REG_AW]
i_src_data  in  NSRC*DATA_W  register-file read values
o_src_data  out  NSRC*DATA_W  forwarded operand values
o_fwd_sel  out  NSRC*SEL_W  per-source select: 0 = register file, k = entry k-1
o_stall  out  1  load-use hazard; hold E and earlier stages
o_stall_cnt  out  16  saturating count of cycles with o_stall=1

Behaviour:
- Clocking: one clock, i_clk. Reset i_rst is synchronous and active-high.
- Entry state, per entry: valid, we, rd, isload, ready, data.
- Reset: all entry valid bits cleared; o_stall_cnt=0.
  - Outputs are combinational from entries, so after reset: o_src_data = i_src_data, o_fwd_sel = 0, o_stall = 0.
  - Reset has priority over i_adv and i_flush.
- i_adv=0: all entries hold; no state change except o_stall_cnt.
- i_adv=1: entries shift, entry k+1 <= entry k (the oldest entry is dropped). Entry 0 loads:
  - a bubble (valid=0) if i_flush=1 or o_stall=1;
  - otherwise {valid=1, we=i_e_we, rd=i_e_rd, isload=i_e_isload, ready=!i_e_isload, data=i_e_result}.
- Load completion: when entry 0 is a valid load, i_adv=1 and it shifts into entry 1, entry 1 captures data=i_m_loaddata and ready=1.
- Match per source s: entry k matches when valid && we && rd==i_src_reg[s] && rd!=0.
- Selection picks the youngest match (lowest k).
  - If that match is ready: o_src_data[s]=data[k], o_fwd_sel[s]=k+1.
  - If that match is not ready: o_stall=1, o_src_data[s]=i_src_data[s], o_fwd_sel[s]=0.
  - No match: register-file path, o_fwd_sel[s]=0.
- Older ready matches never override a younger not-ready match.
- o_stall is the OR over all sources. Its only cause is a load in entry 0 matched by a source; load-use latency is exactly 1 bubble.
- i_flush with o_stall: a bubble is inserted either way; no double-count.
- o_stall_cnt increments each cycle o_stall=1 and saturates at 16'hFFFF. It is not affected by i_adv.
- Multiple sources matching the same entry: each source is forwarded independently.
- Source index 0: always the register-file value, even if an entry targets r0.

Test Plan:
- Reset, then i_src_reg={r3,r4}, i_src_data={0x11,0x22} -> o_src_data={0x11,0x22}, o_fwd_sel={0,0}, o_stall=0.
- Issue ALU op r3<=0xAAAA (adv), next cycle read r3 -> o_fwd_sel[0]=1, data 0xAAAA. Issue an unrelated op (adv) -> sel=2, data 0xAAAA. After DEPTH advances -> sel=0, data from the register file.
- Back-to-back writes r5<=1 then r5<=2, read r5 -> youngest wins: data 2, sel=1.
- Load r7 with i_e_result=0x100 (adv), read r7 -> o_stall=1. Adv with i_m_loaddata=0xBEEF -> bubble inserted, entry 1 ready, o_stall=0, o_src_data=0xBEEF, sel=2, o_stall_cnt=1.
- Write to r0 with 0x55, read r0 -> sel=0, register-file value. i_flush on a write to r9 -> later read r9 gives sel=0.
- Hold a load-use stall with i_adv=0 for 70000 cycles -> o_stall_cnt saturates at 0xFFFF. Assert i_rst mid-stall -> next cycle all entries invalid, o_stall=0, o_stall_cnt=0.
